// File: rtl/datamem_arbiter.sv
// Two-port arbiter for a single-port, sync-read data memory: core (C) and loader (L).
// Fixed L>C priority by default; define ROUND_ROBIN_EN for alternating grants on contention.
module datamem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic              c_ack_o,
    output logic [DATA_W-1:0] c_rdata_o,
    input  logic              l_req_i,
    input  logic              l_we_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [DATA_W-1:0] l_wdata_i,
    output logic              l_ack_o,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              core_stall_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                port_q;     // 1 = loader owns the transaction
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   c_rdata_q, l_rdata_q;
    logic                any_req, grant_l;

    assign any_req = c_req_i | l_req_i;

`ifdef ROUND_ROBIN_EN
    logic last_l_q;  // 1 = loader was granted last
    assign grant_l = l_req_i & (~c_req_i | ~last_l_q);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            last_l_q <= 1'b0;
        else if (state_q == IDLE && any_req)
            last_l_q <= grant_l;
    end
`else
    // Loader always wins; a continuously requesting loader starves the core.
    assign grant_l = l_req_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                port_q  <= grant_l;
                we_q    <= grant_l ? l_we_i    : c_we_i;
                addr_q  <= grant_l ? l_addr_i  : c_addr_i;
                wdata_q <= grant_l ? l_wdata_i : c_wdata_i;
            end
            if (c_ack_o && !we_q) c_rdata_q <= mem_rdata_i;
            if (l_ack_o && !we_q) l_rdata_q <= mem_rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the write strobe and acks in the same cycle it is raised.
    always_comb begin
        mem_we_o = 1'b0;
        c_ack_o  = 1'b0;
        l_ack_o  = 1'b0;
        case (state_q)
            ACCESS: mem_we_o = we_q & ~rst_i;
            RESP: begin
                c_ack_o = ~port_q & ~rst_i;
                l_ack_o =  port_q & ~rst_i;
            end
            default: ;
        endcase
    end

    // Address/data registers are loaded at grant, so they already hold the
    // transaction values during ACCESS and keep them afterwards.
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign c_rdata_o    = (c_ack_o && !we_q) ? mem_rdata_i : c_rdata_q;
    assign l_rdata_o    = (l_ack_o && !we_q) ? mem_rdata_i : l_rdata_q;
    assign core_stall_o = c_req_i & ~c_ack_o;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a sync-read memory and an ack scoreboard.
module tb_datamem_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        c_req_i, c_we_i, l_req_i, l_we_i;
    logic [4:0]  c_addr_i, l_addr_i;
    logic [31:0] c_wdata_i, l_wdata_i;
    logic        c_ack_o, l_ack_o, mem_we_o, core_stall_o, busy_o;
    logic [31:0] c_rdata_o, l_rdata_o, mem_wdata_o, mem_rdata_i;
    logic [4:0]  mem_addr_o;

    int checks = 0;
    int errors = 0;

    typedef struct { bit port; bit rd; logic [31:0] data; } exp_t;
    exp_t        sb[$];
    logic [31:0] model [32];
    logic [31:0] mem   [32];

    datamem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
        .c_ack_o(c_ack_o), .c_rdata_o(c_rdata_o),
        .l_req_i(l_req_i), .l_we_i(l_we_i), .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i),
        .l_ack_o(l_ack_o), .l_rdata_o(l_rdata_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .core_stall_o(core_stall_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input bit p, input bit r, input bit we, input logic [4:0] a,
                           input logic [31:0] d);
        if (p) begin l_req_i = r; l_we_i = we; l_addr_i = a; l_wdata_i = d; end
        else   begin c_req_i = r; c_we_i = we; c_addr_i = a; c_wdata_i = d; end
    endtask

    task automatic push_exp(input bit p, input bit we, input logic [4:0] a, input logic [31:0] d);
        if (we) begin
            model[a] = d;
            sb.push_back('{p, 1'b0, 32'h0});
        end else
            sb.push_back('{p, 1'b1, model[a]});
    endtask

    // One uncontended transaction: IDLE -> ACCESS -> RESP, requester drops req on ack.
    task automatic single(input bit p, input bit we, input logic [4:0] a, input logic [31:0] d);
        set_req(p, 1'b1, we, a, d);
        push_exp(p, we, a, d);
        #2;
        chk("idle_busy", busy_o, 0);
        if (!p) chk("idle_stall", core_stall_o, 1);
        cyc(); #2;
        chk("acc_we", mem_we_o, we);
        chk("acc_addr", mem_addr_o, a);
        if (we) chk("acc_wdata", mem_wdata_o, d);
        chk("acc_busy", busy_o, 1);
        cyc(); #2;
        chk("resp_ack", p ? l_ack_o : c_ack_o, 1);
        chk("resp_we", mem_we_o, 0);
        if (!p) chk("resp_stall", core_stall_o, 0);
        set_req(p, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc();
    endtask

    // Scoreboard: every ack must match the oldest outstanding grant.
    always @(negedge clk_i) begin
        if (c_ack_o && l_ack_o) begin
            checks++; errors++;
            $error("FAIL both_acks observed=11 expected=single");
        end else if (c_ack_o || l_ack_o) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $error("FAIL ack_no_grant observed=ack expected=none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", l_ack_o, e.port);
                if (e.rd) chk("ack_rdata", l_ack_o ? l_rdata_o : c_rdata_o, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; model[i] = 32'h0; end
        rst_i = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc(); cyc();
        rst_i = 1'b0;

        // Reset state, idle with no requests
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rst_flags", {c_ack_o, l_ack_o, mem_we_o, busy_o, core_stall_o}, 0);
            chk("rst_rdata", {c_rdata_o, l_rdata_o}, 0);
            chk("rst_mem", {mem_addr_o, mem_wdata_o}, 0);
            cyc();
        end

        // Core write then read back, capture register holds data afterwards
        single(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        single(1'b0, 1'b0, 5'd5, 32'h0);
        #2 chk("c_rdata_hold", c_rdata_o, 32'hDEADBEEF);
        chk("l_rdata_untouched", l_rdata_o, 0);
        cyc();

        // Contention: loader write @3 wins, core read @3 served next and sees it
        set_req(1'b1, 1'b1, 1'b1, 5'd3, 32'h11);
        set_req(1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
        push_exp(1'b1, 1'b1, 5'd3, 32'h11);
        push_exp(1'b0, 1'b0, 5'd3, 32'h0);
        for (int k = 0; k < 7; k++) begin
            #2;
            chk("t3_stall", core_stall_o, k <= 4);
            chk("t3_lack", l_ack_o, k == 2);
            chk("t3_cack", c_ack_o, k == 5);
            if (k == 2) set_req(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            if (k == 5) set_req(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            cyc();
        end

        // Both requests held after a fresh reset
        rst_i = 1'b1; cyc(); rst_i = 1'b0;
        set_req(1'b1, 1'b1, 1'b0, 5'd5, 32'h0);
        set_req(1'b0, 1'b1, 1'b0, 5'd5, 32'h0);
`ifdef ROUND_ROBIN_EN
        push_exp(1'b1, 1'b0, 5'd5, 0); push_exp(1'b0, 1'b0, 5'd5, 0);
        push_exp(1'b1, 1'b0, 5'd5, 0); push_exp(1'b0, 1'b0, 5'd5, 0);
        for (int k = 0; k < 13; k++) begin
            #2;
            chk("rr_lack", l_ack_o, k == 2 || k == 8);
            chk("rr_cack", c_ack_o, k == 5 || k == 11);
            if (k == 11) begin
                set_req(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
                set_req(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            end
            cyc();
        end
`else
        push_exp(1'b1, 1'b0, 5'd5, 0); push_exp(1'b1, 1'b0, 5'd5, 0);
        push_exp(1'b1, 1'b0, 5'd5, 0); push_exp(1'b0, 1'b0, 5'd5, 0);
        for (int k = 0; k < 13; k++) begin
            #2;
            chk("fp_lack", l_ack_o, k == 2 || k == 5 || k == 8);
            chk("fp_cack", c_ack_o, k == 11);
            if (k == 8)  set_req(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            if (k == 11) set_req(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            cyc();
        end
`endif

        // Reset during ACCESS aborts the write
        single(1'b1, 1'b1, 5'd31, 32'h12345678);
        set_req(1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF);
        cyc();
        rst_i = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #2 chk("abort_we_gated", mem_we_o, 0);
        cyc();
        rst_i = 1'b0;
        #2;
        chk("abort_flags", {c_ack_o, l_ack_o, busy_o, mem_we_o}, 0);
        chk("abort_mem", {mem_addr_o, mem_wdata_o}, 0);
        cyc();
        single(1'b0, 1'b0, 5'd31, 32'h0);

        // Reset during RESP suppresses the ack
        set_req(1'b0, 1'b1, 1'b0, 5'd5, 32'h0);
        cyc(); cyc();
        rst_i = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #2 chk("resp_rst_noack", c_ack_o, 0);
        cyc();
        rst_i = 1'b0;
        #2;
        chk("resp_rst_idle", busy_o, 0);
        chk("resp_rst_rdata", c_rdata_o, 0);
        cyc();

        // Loader back-to-back reads @31 then @0, req held across the ack
        single(1'b1, 1'b1, 5'd0, 32'hA5A5A5A5);
        set_req(1'b1, 1'b1, 1'b0, 5'd31, 32'h0);
        push_exp(1'b1, 1'b0, 5'd31, 0);
        for (int k = 0; k < 7; k++) begin
            #2;
            chk("b2b_lack", l_ack_o, k == 2 || k == 5);
            if (k == 2) begin
                set_req(1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
                push_exp(1'b1, 1'b0, 5'd0, 0);
            end
            if (k == 5) set_req(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            cyc();
        end
        #2 chk("l_rdata_hold", l_rdata_o, 32'hA5A5A5A5);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
